// File: rtl/mdu_pkg.sv
// Shared MDU operation encodings and small decode helpers.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    // Multiply and divide are the only ops that occupy the unit for several cycles.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op[2:1] == 2'b01);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the issuing logic and the MDU.
interface mdu_if;
    import mdu_pkg::*;

    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, A, B, input busy, hi, lo);
    modport slave  (input start, op, A, B, output busy, hi, lo);

endinterface

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO result registers and a fixed-latency busy window.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | accepting requests; MTHI/MTLO complete here in one edge
// ST_BUSY | multiply/divide in flight; counter counts down to completion
module mdu
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic clk,
    input  logic rst_n,
    mdu_if.slave bus
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    op_e                r_op;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        w_hi_nxt;
    logic [31:0]        w_lo_nxt;
    logic               w_accept_long;
    logic               w_done;

    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic               w_div_safe;
    logic signed [31:0] w_a_s;
    logic signed [31:0] w_b_s_safe;
    logic signed [31:0] w_quo_s;
    logic signed [31:0] w_rem_s;
    logic [31:0]        w_b_u_safe;
    logic [31:0]        w_quo_u;
    logic [31:0]        w_rem_u;

    // Datapath on the latched operands; latency is modelled by the counter alone.
    // Divisors of 0 and -1 are steered away from the divider: 0 writes nothing and
    // -1 is a plain negate, which also gives the wrapped 0x80000000 / -1 result.
    assign w_prod_s   = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_prod_u   = {32'd0, r_a} * {32'd0, r_b};
    assign w_div_safe = (r_b != 32'd0) && (r_b != 32'hFFFF_FFFF);
    assign w_a_s      = r_a;
    assign w_b_s_safe = w_div_safe ? r_b : 32'sd1;
    assign w_quo_s    = w_a_s / w_b_s_safe;
    assign w_rem_s    = w_a_s % w_b_s_safe;
    assign w_b_u_safe = (r_b == 32'd0) ? 32'd1 : r_b;
    assign w_quo_u    = r_a / w_b_u_safe;
    assign w_rem_u    = r_a % w_b_u_safe;

    // Next-state and down-counter: load on accept, finish at terminal count 1.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_accept_long = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start && is_long_op(bus.op)) begin
                    w_accept_long = 1'b1;
                    w_state_nxt   = ST_BUSY;
                    w_cnt_nxt     = is_div_op(bus.op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                end
            end
            ST_BUSY: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Result selection: completion of a long op, or a move while idle.
    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (w_done) begin
            case (r_op)
                OP_MULT:  {w_hi_nxt, w_lo_nxt} = w_prod_s;
                OP_MULTU: {w_hi_nxt, w_lo_nxt} = w_prod_u;
                OP_DIV: begin
                    if (r_b == 32'hFFFF_FFFF) begin
                        w_lo_nxt = 32'd0 - r_a;
                        w_hi_nxt = 32'd0;
                    end else if (r_b != 32'd0) begin
                        w_lo_nxt = w_quo_s;
                        w_hi_nxt = w_rem_s;
                    end
                end
                OP_DIVU: begin
                    if (r_b != 32'd0) begin
                        w_lo_nxt = w_quo_u;
                        w_hi_nxt = w_rem_u;
                    end
                end
                default: ;
            endcase
        end else if (r_state == ST_IDLE && bus.start) begin
            if (bus.op == OP_MTHI) begin
                w_hi_nxt = bus.A;
            end else if (bus.op == OP_MTLO) begin
                w_lo_nxt = bus.A;
            end
        end
    end

    // FSM state and latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Operand capture for multiply/divide requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op <= OP_MULT;
            r_a  <= '0;
            r_b  <= '0;
        end else if (w_accept_long) begin
            r_op <= op_e'(bus.op);
            r_a  <= bus.A;
            r_b  <= bus.B;
        end
    end

    // HI/LO architectural registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
        end
    end

    assign bus.busy = (r_state == ST_BUSY);
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
